// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit:
// FSM state encoding, opcode/funct constants, datapath select encodings
// and the branch-condition helper.
package unidade_controle_pkg;

  typedef enum logic [5:0] {
    S_RESET, S_FETCH, S_MEM_WAIT_F, S_IR_LOAD, S_DECODE,
    S_ADD, S_SUB, S_AND, S_SLT, S_WB_R,
    S_ADDI, S_ADDIU, S_WB_I, S_LUI,
    S_BRANCH, S_BR_TAKEN,
    S_MEM_ADDR, S_LW_ACC, S_LW_WAIT, S_SW_ACC, S_SW_WAIT, S_MDR_LOAD, S_LW_WB,
    S_MULT_START, S_MULT_WAIT, S_DIV_START, S_DIV_WAIT, S_MFHI, S_MFLO,
    S_JUMP, S_JAL_LINK, S_JR, S_BREAK, S_RTE, S_EXC, S_EXC_JUMP
  } state_t;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_RTE   = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // select encodings
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_EPC    = 2'd3;

  localparam logic [1:0] IORD_PC     = 2'd0;
  localparam logic [1:0] IORD_ALUOUT = 2'd1;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;
  localparam logic [1:0] RD_SP = 2'd3;

  localparam logic [2:0] M2R_ALUOUT = 3'd0;
  localparam logic [2:0] M2R_MDR    = 3'd1;
  localparam logic [2:0] M2R_HI     = 3'd2;
  localparam logic [2:0] M2R_LO     = 3'd3;
  localparam logic [2:0] M2R_LUI    = 3'd4;
  localparam logic [2:0] M2R_PC     = 3'd5;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] EXC_INVALID = 2'd0;
  localparam logic [1:0] EXC_OVF     = 2'd1;
  localparam logic [1:0] EXC_DIVZ    = 2'd2;
  localparam logic [1:0] EXC_RTE     = 2'd3;

  // Branch condition from the A-vs-B compare flags.
  function automatic logic branch_taken(input logic [5:0] op, input logic et,
                                        input logic gt, input logic lt);
    case (op)
      OP_BEQ:  return et;
      OP_BNE:  return !et;
      OP_BLE:  return lt | et;
      OP_BGT:  return gt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory wait-state counter.
// Ports: clk, reset (sync, active-high), load (load load_val),
// dec (decrement while nonzero), load_val[3:0], zero (count == 0).
module contador_espera (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= 4'd0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != 4'd0))
      cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/unidade_controle_mc.sv
// Multicycle control unit (Moore FSM) for the MIPS-subset datapath.
// Inputs: clk, reset (sync, active-high), opcode/funct from IR, ALU flags
// ET/GT/LT/overflow, mult/div handshake muldiv_done/div_zero.
// Outputs: every datapath mux select and write enable, start pulses for
// the mult/div unit, EPC write/cause for exceptions, and state for debug.
module unidade_controle_mc
  import unidade_controle_pkg::*;
#(
  parameter int         MEM_WAIT    = 1,
  parameter logic [2:0] SP_INIT_SEL = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ET,
  input  logic       GT,
  input  logic       LT,
  input  logic       overflow,
  input  logic       muldiv_done,
  input  logic       div_zero,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic [1:0] IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [2:0] MemToReg,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] ALUop,
  output logic       MultStart,
  output logic       DivStart,
  output logic       EPCWrite,
  output logic [1:0] ExcCause,
  output logic [5:0] state
);

  localparam bit         NO_WAIT   = (MEM_WAIT == 0);
  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     cur, nxt;
  logic [1:0] cause_q, cause_d;
  logic       cnt_load, cnt_dec, cnt_zero;

  // Counter is loaded in the cycle that issues the address, so the wait
  // state that follows sees MEM_WAIT-1 and leaves when it reaches 0.
  assign cnt_load = (cur == S_FETCH) || (cur == S_LW_ACC) || (cur == S_SW_ACC);
  assign cnt_dec  = (cur == S_MEM_WAIT_F) || (cur == S_LW_WAIT) || (cur == S_SW_WAIT);

  contador_espera u_espera (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_RESET;
      cause_q <= EXC_INVALID;
    end else begin
      cur     <= nxt;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    nxt     = cur;
    cause_d = cause_q;
    case (cur)
      S_RESET:      nxt = S_FETCH;
      S_FETCH:      nxt = NO_WAIT ? S_IR_LOAD : S_MEM_WAIT_F;
      S_MEM_WAIT_F: if (cnt_zero) nxt = S_IR_LOAD;
      S_IR_LOAD:    nxt = S_DECODE;
      S_DECODE: begin
        // Cause is only observed in EXC, so it can be primed unconditionally.
        nxt     = S_EXC;
        cause_d = EXC_INVALID;
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD:   nxt = S_ADD;
              FN_SUB:   nxt = S_SUB;
              FN_AND:   nxt = S_AND;
              FN_SLT:   nxt = S_SLT;
              FN_JR:    nxt = S_JR;
              FN_MULT:  nxt = S_MULT_START;
              FN_DIV:   nxt = S_DIV_START;
              FN_MFHI:  nxt = S_MFHI;
              FN_MFLO:  nxt = S_MFLO;
              FN_BREAK: nxt = S_BREAK;
              FN_RTE:   nxt = S_RTE;
              default:  nxt = S_EXC;
            endcase
          end
          OP_ADDI:  nxt = S_ADDI;
          OP_ADDIU: nxt = S_ADDIU;
          OP_BEQ, OP_BNE, OP_BLE, OP_BGT: nxt = S_BRANCH;
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_LUI:   nxt = S_LUI;
          OP_J:     nxt = S_JUMP;
          OP_JAL:   nxt = S_JAL_LINK;
          default:  nxt = S_EXC;
        endcase
      end
      S_ADD, S_SUB: begin
        if (overflow) begin
          nxt     = S_EXC;
          cause_d = EXC_OVF;
        end else begin
          nxt = S_WB_R;
        end
      end
      S_AND, S_SLT: nxt = S_WB_R;
      S_ADDI: begin
        if (overflow) begin
          nxt     = S_EXC;
          cause_d = EXC_OVF;
        end else begin
          nxt = S_WB_I;
        end
      end
      S_ADDIU:      nxt = S_WB_I;
      S_WB_R, S_WB_I, S_LUI: nxt = S_FETCH;
      S_BRANCH:     nxt = branch_taken(opcode, ET, GT, LT) ? S_BR_TAKEN : S_FETCH;
      S_BR_TAKEN:   nxt = S_FETCH;
      S_MEM_ADDR:   nxt = (opcode == OP_LW) ? S_LW_ACC : S_SW_ACC;
      S_LW_ACC:     nxt = NO_WAIT ? S_MDR_LOAD : S_LW_WAIT;
      S_LW_WAIT:    if (cnt_zero) nxt = S_MDR_LOAD;
      S_SW_ACC:     nxt = NO_WAIT ? S_FETCH : S_SW_WAIT;
      S_SW_WAIT:    if (cnt_zero) nxt = S_FETCH;
      S_MDR_LOAD:   nxt = S_LW_WB;
      S_LW_WB:      nxt = S_FETCH;
      S_MULT_START: nxt = S_MULT_WAIT;
      S_MULT_WAIT:  if (muldiv_done) nxt = S_FETCH;
      S_DIV_START:  nxt = S_DIV_WAIT;
      S_DIV_WAIT: begin
        // A zero divisor wins over a simultaneous done.
        if (div_zero) begin
          nxt     = S_EXC;
          cause_d = EXC_DIVZ;
        end else if (muldiv_done) begin
          nxt = S_FETCH;
        end
      end
      S_MFHI, S_MFLO, S_JUMP, S_JR, S_BREAK, S_RTE: nxt = S_FETCH;
      S_JAL_LINK:   nxt = S_JUMP;
      S_EXC:        nxt = S_EXC_JUMP;
      S_EXC_JUMP:   nxt = S_FETCH;
      default:      nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    PCSource  = PCS_ALU;
    IorD      = IORD_PC;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = RD_RT;
    MemToReg  = M2R_ALUOUT;
    RegWrite  = 1'b0;
    AluSrcA   = 1'b0;
    AluSrcB   = SRCB_B;
    ALUop     = ALU_ADD;
    MultStart = 1'b0;
    DivStart  = 1'b0;
    EPCWrite  = 1'b0;
    ExcCause  = 2'd0;
    case (cur)
      S_RESET: begin
        RegWrite = 1'b1;
        RegDst   = RD_SP;
        MemToReg = SP_INIT_SEL;
      end
      S_FETCH: begin
        IorD     = IORD_PC;
        AluSrcB  = SRCB_4;
        PCWrite  = 1'b1;
        PCSource = PCS_ALU;
      end
      S_IR_LOAD: IRWrite = 1'b1;
      S_DECODE:  AluSrcB = SRCB_IMM_SL;
      S_ADD: begin AluSrcA = 1'b1; ALUop = ALU_ADD; end
      S_SUB: begin AluSrcA = 1'b1; ALUop = ALU_SUB; end
      S_AND: begin AluSrcA = 1'b1; ALUop = ALU_AND; end
      S_SLT: begin AluSrcA = 1'b1; ALUop = ALU_SLT; end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = RD_RD;
      end
      S_ADDI, S_ADDIU, S_MEM_ADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
      end
      S_WB_I: RegWrite = 1'b1;
      S_LUI: begin
        RegWrite = 1'b1;
        MemToReg = M2R_LUI;
      end
      S_BRANCH: begin
        AluSrcA = 1'b1;
        ALUop   = ALU_SUB;
      end
      S_BR_TAKEN: begin
        PCWrite  = 1'b1;
        PCSource = PCS_ALUOUT;
      end
      S_LW_ACC, S_LW_WAIT, S_SW_WAIT: IorD = IORD_ALUOUT;
      S_SW_ACC: begin
        IorD     = IORD_ALUOUT;
        MemWrite = 1'b1;
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        MemToReg = M2R_MDR;
      end
      S_MULT_START: MultStart = 1'b1;
      S_DIV_START:  DivStart  = 1'b1;
      S_MFHI: begin
        RegWrite = 1'b1;
        RegDst   = RD_RD;
        MemToReg = M2R_HI;
      end
      S_MFLO: begin
        RegWrite = 1'b1;
        RegDst   = RD_RD;
        MemToReg = M2R_LO;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_JAL_LINK: begin
        RegWrite = 1'b1;
        RegDst   = RD_RA;
        MemToReg = M2R_PC;
      end
      S_JR: begin
        AluSrcA  = 1'b1;
        PCWrite  = 1'b1;
      end
      S_BREAK: begin
        // PC - 4 rewinds onto the break itself, so the core spins here.
        AluSrcB = SRCB_4;
        ALUop   = ALU_SUB;
        PCWrite = 1'b1;
      end
      S_RTE: begin
        PCWrite  = 1'b1;
        PCSource = PCS_EPC;
        ExcCause = EXC_RTE;
      end
      S_EXC: begin
        EPCWrite = 1'b1;
        AluSrcB  = SRCB_4;
        ALUop    = ALU_SUB;
        ExcCause = cause_q;
      end
      S_EXC_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_EPC;
        ExcCause = cause_q;
      end
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_unidade_controle_mc.sv
module tb_unidade_controle_mc;
  import unidade_controle_pkg::*;

  typedef struct packed {
    logic       pcwrite;
    logic [1:0] pcsource;
    logic [1:0] iord;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [2:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       multstart;
    logic       divstart;
    logic       epcwrite;
    logic [1:0] exccause;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  rst;
    logic  st_reset;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h0, funct = 6'h0;
  logic       et = 0, gt = 0, lt = 0, ovf = 0, done = 0, dz = 0;

  wire [23:0] v0, v3;
  wire [5:0]  st0, st3;

  int  total = 0;
  int  bad = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  unidade_controle_mc #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .ET(et), .GT(gt), .LT(lt), .overflow(ovf), .muldiv_done(done), .div_zero(dz),
    .PCWrite(v0[23]), .PCSource(v0[22:21]), .IorD(v0[20:19]), .MemWrite(v0[18]),
    .IRWrite(v0[17]), .RegDst(v0[16:15]), .MemToReg(v0[14:12]), .RegWrite(v0[11]),
    .AluSrcA(v0[10]), .AluSrcB(v0[9:8]), .ALUop(v0[7:5]), .MultStart(v0[4]),
    .DivStart(v0[3]), .EPCWrite(v0[2]), .ExcCause(v0[1:0]), .state(st0)
  );

  unidade_controle_mc #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .ET(et), .GT(gt), .LT(lt), .overflow(ovf), .muldiv_done(done), .div_zero(dz),
    .PCWrite(v3[23]), .PCSource(v3[22:21]), .IorD(v3[20:19]), .MemWrite(v3[18]),
    .IRWrite(v3[17]), .RegDst(v3[16:15]), .MemToReg(v3[14:12]), .RegWrite(v3[11]),
    .AluSrcA(v3[10]), .AluSrcB(v3[9:8]), .ALUop(v3[7:5]), .MultStart(v3[4]),
    .DivStart(v3[3]), .EPCWrite(v3[2]), .ExcCause(v3[1:0]), .state(st3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected output vectors, one per controller phase.
  function automatic outs_t e_none();
    outs_t e = '0;
    return e;
  endfunction
  function automatic outs_t e_reset();
    outs_t e = '0;
    e.regwrite = 1'b1; e.regdst = 2'd3; e.memtoreg = 3'd7;
    return e;
  endfunction
  function automatic outs_t e_fetch();
    outs_t e = '0;
    e.pcwrite = 1'b1; e.alusrcb = 2'd1;
    return e;
  endfunction
  function automatic outs_t e_ir();
    outs_t e = '0;
    e.irwrite = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_dec();
    outs_t e = '0;
    e.alusrcb = 2'd3;
    return e;
  endfunction
  function automatic outs_t e_add();
    outs_t e = '0;
    e.alusrca = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_wbr();
    outs_t e = '0;
    e.regwrite = 1'b1; e.regdst = 2'd1;
    return e;
  endfunction
  function automatic outs_t e_exc(input logic [1:0] c);
    outs_t e = '0;
    e.epcwrite = 1'b1; e.alusrcb = 2'd1; e.aluop = 3'd1; e.exccause = c;
    return e;
  endfunction
  function automatic outs_t e_excj(input logic [1:0] c);
    outs_t e = '0;
    e.pcwrite = 1'b1; e.pcsource = 2'd3; e.exccause = c;
    return e;
  endfunction
  function automatic outs_t e_addr();
    outs_t e = '0;
    e.alusrca = 1'b1; e.alusrcb = 2'd2;
    return e;
  endfunction
  function automatic outs_t e_mem(input logic w);
    outs_t e = '0;
    e.iord = 2'd1; e.memwrite = w;
    return e;
  endfunction
  function automatic outs_t e_lwwb();
    outs_t e = '0;
    e.regwrite = 1'b1; e.memtoreg = 3'd1;
    return e;
  endfunction
  function automatic outs_t e_start(input logic m, input logic d);
    outs_t e = '0;
    e.multstart = m; e.divstart = d;
    return e;
  endfunction
  function automatic outs_t e_br();
    outs_t e = '0;
    e.alusrca = 1'b1; e.aluop = 3'd1;
    return e;
  endfunction
  function automatic outs_t e_brt();
    outs_t e = '0;
    e.pcwrite = 1'b1; e.pcsource = 2'd1;
    return e;
  endfunction
  function automatic outs_t e_jal();
    outs_t e = '0;
    e.regwrite = 1'b1; e.regdst = 2'd2; e.memtoreg = 3'd5;
    return e;
  endfunction
  function automatic outs_t e_j();
    outs_t e = '0;
    e.pcwrite = 1'b1; e.pcsource = 2'd2;
    return e;
  endfunction

  // rst is the reset level driven after this cycle has been checked.
  task automatic push(input outs_t e, input logic r);
    sb.push_back('{o: e, rst: r, st_reset: 1'b0});
  endtask
  task automatic push_rst(input logic r);
    sb.push_back('{o: e_reset(), rst: r, st_reset: 1'b1});
  endtask
  task automatic push_n(input outs_t e, input int n);
    for (int k = 0; k < n; k++) push(e, 1'b0);
  endtask
  // Two reset edges, then release; common prologue of every scenario.
  task automatic push_prologue();
    push_rst(1'b1);
    push_rst(1'b0);
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                        input logic e, input logic g, input logic l,
                        input logic o, input logic d, input logic z);
    opcode = op; funct = fn; et = e; gt = g; lt = l; ovf = o; done = d; dz = z;
  endtask

  task automatic run(input string name, input bit sel3);
    int i = 0;
    sb_t ent;
    reset = 1'b1;
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      @(negedge clk);
      chk($sformatf("%s[%0d]", name, i), {8'h0, (sel3 ? v3 : v0)}, {8'h0, ent.o});
      if (ent.st_reset)
        chk($sformatf("%s_state[%0d]", name, i), {26'h0, (sel3 ? st3 : st0)}, {26'h0, S_RESET});
      reset = ent.rst;
      i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // add with overflow in compute: trap with cause 1, no writeback
    set_in(6'h00, 6'h20, 0, 0, 0, 1, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0); push(e_add(), 0);
    push(e_exc(2'd1), 0); push(e_excj(2'd1), 0); push(e_fetch(), 0);
    run("add_ovf", 0);

    // add without overflow: 5-cycle instruction with rd writeback
    set_in(6'h00, 6'h20, 0, 0, 0, 0, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0); push(e_add(), 0);
    push(e_wbr(), 0); push(e_fetch(), 0);
    run("add", 0);

    // lw with 3 wait states: 13 cycles FETCH..writeback
    set_in(6'h23, 6'h00, 0, 0, 0, 0, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push_n(e_none(), 3); push(e_ir(), 0); push(e_dec(), 0);
    push(e_addr(), 0); push(e_mem(0), 0); push_n(e_mem(0), 3);
    push(e_none(), 0); push(e_lwwb(), 0); push(e_fetch(), 0);
    run("lw_w3", 1);

    // sw with 3 wait states: MemWrite only in the first access cycle
    set_in(6'h2B, 6'h00, 0, 0, 0, 0, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push_n(e_none(), 3); push(e_ir(), 0); push(e_dec(), 0);
    push(e_addr(), 0); push(e_mem(1), 0); push_n(e_mem(0), 3); push(e_fetch(), 0);
    run("sw_w3", 1);

    // div with div_zero and done together: single DivStart, trap cause 2
    set_in(6'h00, 6'h1A, 0, 0, 0, 0, 1, 1);
    push_prologue();
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0); push(e_start(0, 1), 0);
    push(e_none(), 0); push(e_exc(2'd2), 0); push(e_excj(2'd2), 0); push(e_fetch(), 0);
    run("div_zero", 0);

    // ble taken on ET with LT=0
    set_in(6'h06, 6'h00, 1, 0, 0, 0, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0); push(e_br(), 0);
    push(e_brt(), 0); push(e_fetch(), 0);
    run("ble", 0);

    // bgt not taken with GT=0
    set_in(6'h07, 6'h00, 1, 0, 0, 0, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0); push(e_br(), 0);
    push(e_fetch(), 0);
    run("bgt", 0);

    // invalid opcode 0x3F: trap cause 0
    set_in(6'h3F, 6'h00, 0, 0, 0, 0, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0);
    push(e_exc(2'd0), 0); push(e_excj(2'd0), 0); push(e_fetch(), 0);
    run("bad_op", 0);

    // jal: link into $31 then jump
    set_in(6'h03, 6'h00, 0, 0, 0, 0, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0);
    push(e_jal(), 0); push(e_j(), 0); push(e_fetch(), 0);
    run("jal", 0);

    // mult, reset during the wait: RESET next cycle, no extra MultStart
    set_in(6'h00, 6'h18, 0, 0, 0, 0, 0, 0);
    push_prologue();
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0); push(e_start(1, 0), 0);
    push(e_none(), 0); push(e_none(), 1);
    push_rst(1'b0);
    push(e_fetch(), 0); push(e_ir(), 0); push(e_dec(), 0);
    run("mult_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
